// File: rtl/rr_merge.sv
// rr_merge: round-robin SIZE-to-1 valid/ready merge that tags each beat with its source index.
// Define RR_MERGE_EOT_LOCK_EN to hold the grant on one input until a beat with payload MSB (eot) set.
module rr_merge #(
  parameter int SIZE  = 2,
  parameter int DIN_W = 16,
  parameter int IDX_W = $clog2(SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SIZE-1:0]              din_valid_i,
  output logic [SIZE-1:0]              din_ready_o,
  input  logic [SIZE-1:0][DIN_W-1:0]   din_data_i,
  output logic                         dout_valid_o,
  input  logic                         dout_ready_i,
  output logic [DIN_W+IDX_W-1:0]       dout_data_o
);
  logic                   out_valid_q, out_valid_d;
  logic [DIN_W+IDX_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d, g, g_next, jj;
  logic                   load, grant, hs;
  int                     j;
`ifdef RR_MERGE_EOT_LOCK_EN
  logic                   lock_q, lock_d;
  logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;
`endif
  assign load = !out_valid_q || dout_ready_i;
  assign hs   = !rst && load && grant;
  // Scan from the far end back toward ptr so the last hit is the first valid in round-robin order.
  always_comb begin
    grant = 1'b0;
    g     = '0;
    j     = 0;
    jj    = '0;
    for (int k = SIZE - 1; k >= 0; k--) begin
      j  = int'(ptr_q) + k;
      j  = j >= SIZE ? j - SIZE : j;
      jj = j[IDX_W-1:0];
      if (din_valid_i[jj]) begin
        grant = 1'b1;
        g     = jj;
      end
    end
`ifdef RR_MERGE_EOT_LOCK_EN
    if (lock_q) begin
      grant = din_valid_i[lock_idx_q];
      g     = lock_idx_q;
    end
`endif
  end
  always_comb begin
    din_ready_o    = '0;
    din_ready_o[g] = hs;
  end
  always_comb begin
    out_valid_d = hs || (out_valid_q && !dout_ready_i);
    out_data_d  = hs ? {g, din_data_i[g]} : out_data_q;
    g_next      = g == IDX_W'(SIZE - 1) ? '0 : g + 1'b1;
`ifdef RR_MERGE_EOT_LOCK_EN
    ptr_d       = hs && din_data_i[g][DIN_W-1] ? g_next : ptr_q;
    lock_d      = hs ? !din_data_i[g][DIN_W-1] : lock_q;
    lock_idx_d  = hs ? g : lock_idx_q;
`else
    ptr_d       = hs ? g_next : ptr_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ptr_q       <= '0;
`ifdef RR_MERGE_EOT_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ptr_q       <= ptr_d;
`ifdef RR_MERGE_EOT_LOCK_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end
  assign dout_valid_o = out_valid_q;
  assign dout_data_o  = out_data_q;
endmodule

// File: tb/tb_rr_merge.sv
// tb_rr_merge: randomized and directed checks of rr_merge against a cycle-level reference model.
module tb_rr_merge;
`ifdef RR_MERGE_EOT_LOCK_EN
  localparam logic [15:0] EOT = 16'h8000;
`else
  localparam logic [15:0] EOT = 16'h0000;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       a_vld = '0, a_rdy;
  logic [3:0][15:0] a_din = '0;
  logic             a_dv, a_drdy = 1'b0;
  logic [17:0]      a_dd;
  logic [2:0]       b_vld = '0, b_rdy;
  logic [2:0][15:0] b_din = '0;
  logic             b_dv, b_drdy = 1'b0;
  logic [17:0]      b_dd;

  rr_merge #(.SIZE(4), .DIN_W(16)) dut_a (
    .clk(clk), .rst(rst), .din_valid_i(a_vld), .din_ready_o(a_rdy), .din_data_i(a_din),
    .dout_valid_o(a_dv), .dout_ready_i(a_drdy), .dout_data_o(a_dd));
  rr_merge #(.SIZE(3), .DIN_W(16)) dut_b (
    .clk(clk), .rst(rst), .din_valid_i(b_vld), .din_ready_o(b_rdy), .din_data_i(b_din),
    .dout_valid_o(b_dv), .dout_ready_i(b_drdy), .dout_data_o(b_dd));

  int checks = 0, failures = 0;
  // reference model of the SIZE=4 instance
  int          m_ptr = 0, m_lidx = 0;
  bit          m_mv = 0, m_lock = 0;
  logic [17:0] m_md = '0;
  logic [3:0]  exp_rdy, obs_rdy;
  logic [2:0]  obs_b;

  // One clock of dut_a: predict the granted input at mid-cycle, sample ready, then advance the model.
  task automatic cyc_a();
    int g;
    bit gr;
    #4;
    gr = 0;
    g  = 0;
    if (m_lock) begin
      gr = a_vld[m_lidx];
      g  = m_lidx;
    end else
      for (int k = 0; k < 4; k++)
        if (!gr && a_vld[(m_ptr + k) % 4]) begin
          gr = 1;
          g  = (m_ptr + k) % 4;
        end
    exp_rdy = '0;
    if (!rst && gr && (!m_mv || a_drdy)) exp_rdy[g] = 1'b1;
    obs_rdy = a_rdy;
    @(posedge clk);
    if (rst) begin
      m_mv = 0; m_md = '0; m_ptr = 0; m_lock = 0; m_lidx = 0;
    end else if (exp_rdy != 0) begin
      m_md = {2'(g), a_din[g]};
      m_mv = 1;
`ifdef RR_MERGE_EOT_LOCK_EN
      if (a_din[g][15]) begin
        m_lock = 0;
        m_ptr  = (g + 1) % 4;
      end else begin
        m_lock = 1;
        m_lidx = g;
      end
`else
      m_ptr = (g + 1) % 4;
`endif
    end else if (a_drdy) m_mv = 0;
    #1;
  endtask

  task automatic cyc_b();
    #4;
    obs_b = b_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int n = 0; n < 2; n++) begin
      cyc_a();
      checks++;
      if (obs_rdy !== 4'b0) begin failures++; $display("FAIL reset_ready act=%b req=0000", obs_rdy); end
    end
    rst = 0;
    for (int n = 0; n < 10; n++) begin
      cyc_a();
      checks++;
      if (a_dv !== 1'b0 || obs_rdy !== 4'b0 || a_dd !== 18'h0 || b_dv !== 1'b0 || b_rdy !== 3'b0) begin
        failures++;
        $display("FAIL idle cyc=%0d act=v%b r%b d%h bv%b br%b req=all zero", n, a_dv, obs_rdy, a_dd, b_dv, b_rdy);
      end
    end
  endtask

  task automatic test_round_robin();
    a_drdy = 1;
    a_vld  = 4'hF;
    for (int i = 0; i < 4; i++) a_din[i] = EOT | (16'h000A + 16'(i));
    for (int n = 0; n < 12; n++) begin
      cyc_a();
      checks++;
      if (obs_rdy !== 4'(1 << (n % 4)) || a_dv !== 1'b1 || a_dd !== {2'(n % 4), EOT | (16'h000A + 16'(n % 4))}) begin
        failures++;
        $display("FAIL rr_seq cyc=%0d act=r%b v%b d%h req=r%b v1 d%h", n, obs_rdy, a_dv, a_dd,
                 4'(1 << (n % 4)), {2'(n % 4), EOT | (16'h000A + 16'(n % 4))});
      end
    end
  endtask

  task automatic test_backpressure();
    int cnt = 0;
    a_vld  = '0;
    a_drdy = 1;
    cyc_a();
    a_din[2] = 16'h1234;
    a_vld    = 4'b0100;
    a_drdy   = 0;
    for (int n = 0; n < 5; n++) begin
      cyc_a();
      if (obs_rdy[2]) begin cnt++; a_vld[2] = 1'b0; end
      checks++;
      if (obs_rdy !== exp_rdy || a_dv !== 1'b1 || a_dd !== {2'd2, 16'h1234}) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d act=r%b v%b d%h req=r%b v1 d%h", n, obs_rdy, a_dv, a_dd, exp_rdy, {2'd2, 16'h1234});
      end
    end
    checks++;
    if (cnt != 1) begin failures++; $display("FAIL bp_ready_count act=%0d req=1", cnt); end
    a_drdy = 1;
    cyc_a();
    checks++;
    if (a_dv !== 1'b0) begin failures++; $display("FAIL bp_drain act=%b req=0", a_dv); end
  endtask

  task automatic test_reset_mid();
    a_vld  = 4'hF;
    a_drdy = 0;
    for (int i = 0; i < 4; i++) a_din[i] = EOT | (16'h00C0 + 16'(i));
    cyc_a();
    cyc_a();
    checks++;
    if (a_dv !== 1'b1) begin failures++; $display("FAIL rm_pending act=%b req=1", a_dv); end
    rst = 1;
    cyc_a();
    checks++;
    if (obs_rdy !== 4'b0 || a_dv !== 1'b0 || a_dd !== 18'h0) begin
      failures++;
      $display("FAIL rm_reset act=r%b v%b d%h req=r0000 v0 d0", obs_rdy, a_dv, a_dd);
    end
    rst    = 0;
    a_drdy = 1;
    cyc_a();
    checks++;
    if (obs_rdy !== 4'b0001 || a_dv !== 1'b1 || a_dd !== {2'd0, EOT | 16'h00C0}) begin
      failures++;
      $display("FAIL rm_restart act=r%b v%b d%h req=r0001 v1 d%h", obs_rdy, a_dv, a_dd, {2'd0, EOT | 16'h00C0});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      a_drdy = ($urandom_range(0, 3) != 0);
      cyc_a();
      checks++;
      if (obs_rdy !== exp_rdy || a_dv !== m_mv || a_dd !== m_md) begin
        failures++;
        $display("FAIL rand cyc=%0d act=r%b v%b d%h req=r%b v%b d%h", n, obs_rdy, a_dv, a_dd, exp_rdy, m_mv, m_md);
      end
      for (int i = 0; i < 4; i++)
        if (!a_vld[i] || obs_rdy[i]) begin
          a_vld[i] = 1'($urandom_range(0, 1));
          a_din[i] = 16'($urandom);
        end
    end
    rst    = 0;
    a_vld  = '0;
    a_drdy = 1;
    cyc_a();
    cyc_a();
  endtask

  task automatic test_wrap();
    b_drdy   = 1;
    b_din[0] = EOT | 16'h00B0;
    b_din[1] = EOT | 16'h00B1;
    b_vld    = 3'b010;
    cyc_b();
    checks++;
    if (obs_b !== 3'b010 || b_dd !== {2'd1, EOT | 16'h00B1}) begin
      failures++;
      $display("FAIL wrap_setup act=r%b d%h req=r010 d%h", obs_b, b_dd, {2'd1, EOT | 16'h00B1});
    end
    b_vld = 3'b011;
    cyc_b();
    checks++;
    if (obs_b !== 3'b001 || b_dv !== 1'b1 || b_dd !== {2'd0, EOT | 16'h00B0}) begin
      failures++;
      $display("FAIL wrap_first act=r%b v%b d%h req=r001 v1 d%h", obs_b, b_dv, b_dd, {2'd0, EOT | 16'h00B0});
    end
    b_vld = 3'b010;
    cyc_b();
    checks++;
    if (obs_b !== 3'b010 || b_dv !== 1'b1 || b_dd !== {2'd1, EOT | 16'h00B1}) begin
      failures++;
      $display("FAIL wrap_second act=r%b v%b d%h req=r010 v1 d%h", obs_b, b_dv, b_dd, {2'd1, EOT | 16'h00B1});
    end
    b_vld = '0;
    cyc_b();
  endtask

`ifdef RR_MERGE_EOT_LOCK_EN
  task automatic test_lock();
    logic [15:0] beats [3];
    logic [1:0]  idx_q [$];
    logic [1:0]  req [4];
    int bi = 0;
    beats = '{16'h0001, 16'h0002, 16'h8003};
    req   = '{2'd0, 2'd0, 2'd0, 2'd1};
    rst = 1;
    cyc_a();
    rst      = 0;
    a_drdy   = 1;
    a_din[0] = beats[0];
    a_din[1] = 16'h8100;
    a_vld    = 4'b0011;
    for (int n = 0; n < 12 && idx_q.size() < 4; n++) begin
      cyc_a();
      if (a_dv) idx_q.push_back(a_dd[17:16]);
      if (obs_rdy[0]) begin
        bi++;
        if (bi == 3) a_vld[0] = 1'b0;
        else a_din[0] = beats[bi];
      end
      if (obs_rdy[1]) a_vld[1] = 1'b0;
    end
    checks++;
    if (idx_q.size() != 4) begin failures++; $display("FAIL lock_count act=%0d req=4", idx_q.size()); end
    for (int i = 0; i < 4 && i < idx_q.size(); i++) begin
      checks++;
      if (idx_q[i] !== req[i]) begin failures++; $display("FAIL lock_seq beat=%0d act=%0d req=%0d", i, idx_q[i], req[i]); end
    end
    a_vld = '0;
    cyc_a();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
`ifdef RR_MERGE_EOT_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_merge.md
# rr_merge

Round-robin N-to-1 merge for the DTI valid/ready interface, the collecting counterpart of the one-to-many broadcast. It accepts transfers from `SIZE` producer channels, arbitrates fairly among those presenting valid data, and forwards each winning beat through a registered output stage. Every output beat is tagged with the index of its source channel. It sits wherever independent streams converge onto one consumer, such as shared memory ports or result collection after a broadcast fan-out.

## Interface
- `SIZE`, 2: number of input channels; must be at least 2; need not be a power of two.
- `DIN_W`, 16: data width of each input channel.
- `IDX_W`, `$clog2(SIZE)`: derived width of the source index; do not override.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `din[SIZE-1:0]` dti.consumer, `DIN_W`: input channels (`valid`, `ready`, `data`).
- `dout` dti.producer, `DIN_W+IDX_W`: merged output, `data = {idx, payload}`, with `idx` in the MSBs.

## Operation
- State:
  - Output register: `out_valid`, `out_data`.
  - Round-robin pointer `ptr` in the range 0..SIZE-1.
  - When `RR_MERGE_EOT_LOCK_EN` is defined: `lock` flag and `lock_idx`.
- `load = !out_valid || dout.ready`: the output register can accept a new beat this cycle.
- Arbitration is combinational over `din[*].valid`:
  - Search indices `ptr, ptr+1, …, SIZE-1, 0, …, ptr-1`.
  - The first index with valid set wins and is named `g`.
  - If no input is valid, there is no grant.
- `din[i].ready = load && grant && (i == g)`:
  - At most one input is ready in any cycle.
  - `din[*].ready` depends combinationally on `din[*].valid` and `dout.ready`.
- On a handshake with input `g`:
  - `out_data <= {g[IDX_W-1:0], din[g].data}` and `out_valid <= 1`.
  - `ptr <= (g == SIZE-1) ? 0 : g+1`.
- When `dout.ready` is high with `out_valid` set and no new grant: `out_valid <= 0`.
- `dout.valid = out_valid` and `dout.data = out_data`. Both are driven from registers only.
- `out_data` holds its value while `out_valid && !dout.ready`. This meets the DTI rule that data stays stable until accepted.
- `ptr` is unchanged in cycles without an input handshake.
- Fairness: an input that holds `valid` is served within `SIZE` output handshakes.

## Timing
- Reset values:
  - `dout.valid = 0` and `dout.data = 0`.
  - `ptr = 0`, `lock = 0`, `lock_idx = 0`.
  - All `din[*].ready = 0` during the reset cycle, forced by gating with `!rst`.
- Latency: an input handshake in cycle N produces `dout.valid` in cycle N+1.
- Throughput: one beat per cycle when `dout.ready` is held high.
- Simultaneous drain and load: when `out_valid && dout.ready` and a grant exist in the same cycle, the old beat leaves and the new beat is captured with no bubble.
- Backpressure: with `dout.ready = 0` and `out_valid = 1`, every `din[*].ready` is 0 and the whole block stalls.
- Reset mid-operation:
  - A pending output beat is discarded.
  - The input handshake in the reset cycle does not occur.
- Wrap-around: for `SIZE = 3` and `ptr = 2`, the search order is 2, 0, 1.

## Configuration
- Macro `RR_MERGE_EOT_LOCK_EN`.
- Defined (packet lock mode):
  - Bit `DIN_W-1` of the payload is treated as end-of-transaction (eot).
  - After a handshake from `g` with eot = 0: set `lock = 1` and `lock_idx = g`.
  - While locked, only `lock_idx` may win, even if other inputs are valid.
  - A handshake from `lock_idx` with eot = 1 clears `lock`.
  - `ptr` advances only on a handshake with eot = 1.
- Undefined: no lock logic is present, and arbitration restarts every beat as described above.

## Test plan
- Reset then idle: all `din.valid = 0` → `dout.valid = 0`, all `din.ready = 0`, and `ptr = 0` for 10 cycles.
- `SIZE = 4`, all inputs continuously valid with payloads `0x0A + i`, `dout.ready = 1` → output idx sequence 0,1,2,3,0,… at one beat per cycle; first `dout.valid` one cycle after the first handshake.
- Only `din[2]` valid with `0x1234`, `dout.ready = 0` for 5 cycles:
  - `dout.data = {2, 0x1234}` stays stable;
  - `din[2].ready` is 1 for exactly one cycle;
  - after `dout.ready` rises, one beat is delivered.
- `SIZE = 3`, `ptr = 2`, inputs 0 and 1 valid, 2 idle → input 0 wins and `ptr` becomes 1; input 1 wins next.
- Assert `rst` while `out_valid = 1` and inputs are valid → next cycle `dout.valid = 0` and `ptr = 0`; no input handshake in the reset cycle.
- With `RR_MERGE_EOT_LOCK_EN` defined:
  - Input 0 sends 3 beats with eot = 0,0,1 while input 1 is valid throughout.
  - Required output idx sequence: 0,0,0,1.
